// File: rtl/tdm_demux_if.sv
// Bus between a serial TDM link driver and the tdm_demux receive end.
// Slot counter width follows TDM_DEMUX_PARITY_EN (one extra parity slot when defined).
interface tdm_demux_if #(
    parameter int N = 8,
`ifdef TDM_DEMUX_PARITY_EN
    parameter int SEL_W = $clog2(N + 1)
`else
    parameter int SEL_W = $clog2(N)
`endif
);
    logic             din;
    logic             din_valid;
    logic             frame_start;
    logic [N-1:0]     out;
    logic             frame_done;
    logic             sync_err;
    logic             busy;
    logic [SEL_W-1:0] slot;
    logic             par_err;

    modport master (
        output din, din_valid, frame_start,
        input  out, frame_done, sync_err, busy, slot, par_err
    );

    modport slave (
        input  din, din_valid, frame_start,
        output out, frame_done, sync_err, busy, slot, par_err
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive end: collects one serial bit per valid beat into slots, commits a full frame to out.
// Optional even-parity slot at index N is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int N = 8,
`ifdef TDM_DEMUX_PARITY_EN
    parameter int SEL_W = $clog2(N + 1)
`else
    parameter int SEL_W = $clog2(N)
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    tdm_demux_if.slave bus
);
    typedef enum logic {HUNT, RECV} state_t;

    // Without parity the last data bit goes straight to out, so hold needs only N-1 bits.
`ifdef TDM_DEMUX_PARITY_EN
    localparam int HW = N;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N);
`else
    localparam int HW = N - 1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);
`endif
    localparam int IDX_W = (HW > 1) ? $clog2(HW) : 1;

    state_t        state;
    logic [HW-1:0] hold;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_bad;
    assign par_bad = (^hold) ^ bus.din;
`else
    assign bus.par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HUNT;
            hold           <= '0;
            bus.out        <= '0;
            bus.frame_done <= 1'b0;
            bus.sync_err   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.slot       <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            bus.par_err    <= 1'b0;
`endif
        end else begin
            bus.frame_done <= 1'b0;
            bus.sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            bus.par_err    <= 1'b0;
`endif
            if (bus.din_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.frame_start) begin
                            hold[0]  <= bus.din;
                            bus.slot <= SEL_W'(1);
                            bus.busy <= 1'b1;
                            state    <= RECV;
                        end
                    end
                    RECV: begin
                        if (bus.frame_start) begin
                            // Restart mid-frame: the current beat becomes slot 0 of a new frame.
                            bus.sync_err <= 1'b1;
                            hold[0]      <= bus.din;
                            bus.slot     <= SEL_W'(1);
                        end else if (bus.slot == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                            if (par_bad) bus.par_err <= 1'b1;
                            else begin
                                bus.out        <= hold;
                                bus.frame_done <= 1'b1;
                            end
`else
                            bus.out        <= {bus.din, hold};
                            bus.frame_done <= 1'b1;
`endif
                            bus.slot <= '0;
                            bus.busy <= 1'b0;
                            state    <= HUNT;
                        end else begin
                            hold[bus.slot[IDX_W-1:0]] <= bus.din;
                            bus.slot <= bus.slot + SEL_W'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed vector table, corner sequences, random vs. frame-level model.
module tb_tdm_demux;
    localparam int N = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int NS = N + 1;
    localparam int SEL_W = 4;
`else
    localparam int NS = N;
    localparam int SEL_W = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux_if #(.N(N), .SEL_W(SEL_W)) bus ();
    tdm_demux #(.N(N), .SEL_W(SEL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Frame-level reference: bits received in the current frame, last committed word, pulses.
    bit           bits[$];
    bit           in_frame;
    logic [N-1:0] m_out;
    bit           m_done, m_sync, m_par;

    typedef struct {
        bit           v, fs, d;
        logic [N-1:0] e_out;
        bit           e_done, e_busy;
        int           e_slot;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        bits.delete();
        in_frame = 0;
        m_out = '0;
        m_done = 0; m_sync = 0; m_par = 0;
    endfunction

    function automatic void model_step(bit v, bit fs, bit d);
        logic [N-1:0] val;
        bit p;
        m_done = 0; m_sync = 0; m_par = 0;
        if (!v) return;
        if (fs) begin
            if (in_frame) m_sync = 1;
            bits.delete();
            bits.push_back(d);
            in_frame = 1;
        end else if (in_frame) begin
            bits.push_back(d);
            if (bits.size() == NS) begin
                val = '0;
                p = 0;
                for (int i = 0; i < NS; i++) p ^= bits[i];
                for (int i = 0; i < N; i++) val[i] = bits[i];
                if (NS == N || p == 0) begin
                    m_out = val;
                    m_done = 1;
                end else m_par = 1;
                in_frame = 0;
                bits.delete();
            end
        end
    endfunction

    task automatic cmp_model(string tag);
        chk({tag, ".out"},        32'(bus.out),        32'(m_out));
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(m_done));
        chk({tag, ".sync_err"},   32'(bus.sync_err),   32'(m_sync));
        chk({tag, ".busy"},       32'(bus.busy),       32'(in_frame));
        chk({tag, ".slot"},       32'(bus.slot),       32'(bits.size()));
        chk({tag, ".par_err"},    32'(bus.par_err),    32'(m_par));
    endtask

    task automatic step(bit v, bit fs, bit d, string tag);
        bus.din_valid = v; bus.frame_start = fs; bus.din = d;
        @(posedge clk);
        model_step(v, fs, d);
        @(negedge clk);
        cmp_model(tag);
    endtask

    function automatic bit bit_of(logic [N-1:0] val, int i, bit par_bad);
        logic [N-1:0] t;
        t = val;
        return (i < N) ? t[i] : ((^t) ^ par_bad);
    endfunction

    task automatic send_bits(logic [N-1:0] val, int from, int to, bit par_bad, string tag);
        for (int i = from; i <= to; i++) step(1'b1, i == 0, bit_of(val, i, par_bad), tag);
    endtask

    initial begin
        bus.din = 0; bus.din_valid = 0; bus.frame_start = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.out", 32'(bus.out), 0);
        chk("reset.busy", 32'(bus.busy), 0);
        chk("reset.slot", 32'(bus.slot), 0);
        chk("reset.pulses", 32'({bus.frame_done, bus.sync_err, bus.par_err}), 0);
        rst_n = 1;

        // 8'h4D LSB first: 1,0,1,1,0,0,1,0
        tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 4});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 7});
`ifdef TDM_DEMUX_PARITY_EN
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8});
`endif
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h4D, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 1'b0, 0});
        foreach (tbl[i]) begin
            bus.din_valid = tbl[i].v; bus.frame_start = tbl[i].fs; bus.din = tbl[i].d;
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].fs, tbl[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d.out", i),  32'(bus.out),        32'(tbl[i].e_out));
            chk($sformatf("tbl%0d.done", i), 32'(bus.frame_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d.busy", i), 32'(bus.busy),       32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.slot", i), 32'(bus.slot),       32'(tbl[i].e_slot));
        end

        // Valid gap of 3 cycles after slot 3: slot holds at 4.
        send_bits(8'h4D, 0, 3, 0, "gap");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, "gap.idle");
            chk("gap.slot_hold", 32'(bus.slot), 4);
            chk("gap.no_done", 32'(bus.frame_done), 0);
        end
        send_bits(8'h4D, 4, NS - 1, 0, "gap");
        chk("gap.out", 32'(bus.out), 32'h4D);
        chk("gap.done", 32'(bus.frame_done), 1);

        // Commit FF, abort a frame at slot 5, then commit 0F.
        send_bits(8'hFF, 0, NS - 1, 0, "sync");
        chk("sync.out_ff", 32'(bus.out), 32'hFF);
        send_bits(8'hAA, 0, 4, 0, "sync.partial");
        chk("sync.slot5", 32'(bus.slot), 5);
        step(1'b1, 1'b1, 1'b1, "sync.restart");
        chk("sync.err", 32'(bus.sync_err), 1);
        chk("sync.out_hold", 32'(bus.out), 32'hFF);
        send_bits(8'h0F, 1, NS - 1, 0, "sync");
        chk("sync.out_0f", 32'(bus.out), 32'h0F);
        chk("sync.done", 32'(bus.frame_done), 1);

        // HUNT drops beats without frame_start.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'($urandom), "hunt");
        chk("hunt.busy", 32'(bus.busy), 0);
        chk("hunt.out", 32'(bus.out), 32'h0F);

        // Asynchronous reset mid-frame.
        send_bits(8'h5A, 0, 3, 0, "rst");
        bus.din_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("rst.out", 32'(bus.out), 0);
        chk("rst.slot", 32'(bus.slot), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        send_bits(8'hA5, 0, NS - 1, 0, "rst.after");
        chk("rst.after_out", 32'(bus.out), 32'hA5);

`ifdef TDM_DEMUX_PARITY_EN
        send_bits(8'h4D, 0, NS - 1, 1, "par");
        chk("par.err", 32'(bus.par_err), 1);
        chk("par.no_done", 32'(bus.frame_done), 0);
        chk("par.out_hold", 32'(bus.out), 32'hA5);
`endif

        // Random beats, frame starts and occasional parity corruption.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, ($urandom % 12) == 0, 1'($urandom), "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
